// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the handshaked data-memory responder:
//   size_e    - access size encoding carried on req_size
//   state_e   - responder FSM states
//   CNT_W     - width of the wait-state counter
//   access_misaligned() - alignment rule shared by the error check
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Halves need an even address and words a 4-byte aligned address; the
  // illegal size is reported here too so one call covers every shape error.
  function automatic logic access_misaligned(size_e size, logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lsb[0];
      SIZE_W:  bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Load/store port between the core's memory stage (master) and the data
// memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : byte / half / word / illegal
//   req_unsigned        : zero-extend sub-word loads
//   req_wdata           : store data, low bytes used for sub-word stores
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_error           : misaligned, out-of-range or illegal-size access
// -----------------------------------------------------------------------------
interface dmem_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  size_e       req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/dmem_lane.sv
// -----------------------------------------------------------------------------
// dmem_lane
// Combinational byte-lane steering for one access.
//   size, lsb    : access size and address bits [1:0]
//   is_unsigned  : zero-extend sub-word loads when set
//   wdata        : store data from the core (low bytes significant)
//   rword        : raw 32-bit word read from the array
//   be           : byte enables for a store
//   wword        : store data replicated onto every lane the size can hit
//   rdata        : load data shifted to bit 0 and extended
// -----------------------------------------------------------------------------
module dmem_lane
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lsb,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    be      = 4'b0000;
    wword   = wdata;
    rdata   = '0;
    shifted = rword >> {lsb, 3'b000};
    case (size)
      SIZE_B: begin
        be    = 4'b0001 << lsb;
        wword = {4{wdata[7:0]}};
        rdata = is_unsigned ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be    = lsb[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = is_unsigned ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        be    = 4'b1111;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target side of the RV32I load/store port. Accepts one request at a time,
// spends WAIT_STATES cycles before committing, then holds a registered
// response until the core takes it. Bad accesses skip the wait and respond
// with rsp_error = 1 without touching memory.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : dmem_if slave modport (request and response handshakes)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words
//   WAIT_STATES : cycles spent in WAIT before commit (0..15)
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) << 2;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_error_q;

  // Request fields captured at acceptance, used while waiting.
  logic             lat_write;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_lsb;
  size_e            lat_size;
  logic             lat_unsigned;
  logic [31:0]      lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             req_err;
  logic             commit;
  logic             sel_write;
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       sel_lsb;
  size_e            sel_size;
  logic             sel_unsigned;
  logic [31:0]      sel_wdata;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      ld_data;

  assign accept  = bus.req_valid && (state == IDLE);
  assign req_err = access_misaligned(bus.req_size, bus.req_addr[1:0]) ||
                   ({2'b00, bus.req_addr} >= ADDR_LIMIT);

  // With no wait states the access commits on the acceptance edge, so the
  // lanes are fed from the live request in IDLE and from the latch otherwise.
  assign sel_write    = (state == IDLE) ? bus.req_write            : lat_write;
  assign sel_idx      = (state == IDLE) ? bus.req_addr[IDX_W+1:2]  : lat_idx;
  assign sel_lsb      = (state == IDLE) ? bus.req_addr[1:0]        : lat_lsb;
  assign sel_size     = (state == IDLE) ? bus.req_size             : lat_size;
  assign sel_unsigned = (state == IDLE) ? bus.req_unsigned         : lat_unsigned;
  assign sel_wdata    = (state == IDLE) ? bus.req_wdata            : lat_wdata;

  assign commit = !rst &&
                  ((accept && !req_err && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && (cnt == '0)));

  dmem_lane u_lane (
    .size        (sel_size),
    .lsb         (sel_lsb),
    .is_unsigned (sel_unsigned),
    .wdata       (sel_wdata),
    .rword       (mem[sel_idx]),
    .be          (be),
    .wword       (wword),
    .rdata       (ld_data)
  );

  // NOTE: the array has no reset; contents survive rst and only a committed
  // store changes them, which also keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (commit && sel_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[sel_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write    <= bus.req_write;
      lat_idx      <= bus.req_addr[IDX_W+1:2];
      lat_lsb      <= bus.req_addr[1:0];
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
      lat_wdata    <= bus.req_wdata;
    end
  end

  // NOTE: all FSM state and registered outputs use non-blocking assignments
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (WAIT_STATES == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b0;
              rsp_rdata_q <= bus.req_write ? 32'h0 : ld_data;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= lat_write ? 32'h0 : ld_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders share one clock: WAIT_STATES = 1, 3 and 0. Directed
// requests push their hand-computed response into a queue; a monitor on the
// falling edge compares every presented response against the queue head,
// including the cycle it first appears.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int NDUT = 3;

  function automatic int ws_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  logic        rst_a          [NDUT];
  logic        req_valid_a    [NDUT];
  logic        req_write_a    [NDUT];
  logic [31:0] req_addr_a     [NDUT];
  logic [1:0]  req_size_a     [NDUT];
  logic        req_unsigned_a [NDUT];
  logic [31:0] req_wdata_a    [NDUT];
  logic        rsp_ready_a    [NDUT];
  logic        req_ready_a    [NDUT];
  logic        rsp_valid_a    [NDUT];
  logic [31:0] rsp_rdata_a    [NDUT];
  logic        rsp_error_a    [NDUT];

  bit          in_rsp   [NDUT];
  bit          retired  [NDUT];
  int          last_acc [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_if bus ();
    assign bus.req_valid    = req_valid_a[g];
    assign bus.req_write    = req_write_a[g];
    assign bus.req_addr     = req_addr_a[g];
    assign bus.req_size     = size_e'(req_size_a[g]);
    assign bus.req_unsigned = req_unsigned_a[g];
    assign bus.req_wdata    = req_wdata_a[g];
    assign bus.rsp_ready    = rsp_ready_a[g];
    assign req_ready_a[g]   = bus.req_ready;
    assign rsp_valid_a[g]   = bus.rsp_valid;
    assign rsp_rdata_a[g]   = bus.rsp_rdata;
    assign rsp_error_a[g]   = bus.rsp_error;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(ws_of(g))) u_dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every presented response to the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst_a[d]) begin
        in_rsp[d]  = 1'b0;
        retired[d] = 1'b0;
      end else begin
        if (retired[d]) begin
          check($sformatf("idle_after_retire[%0d]", d),
                {30'h0, req_ready_a[d], rsp_valid_a[d]}, 32'h2);
          retired[d] = 1'b0;
        end
        if (rsp_valid_a[d]) begin
          if (exp_q.size() == 0 || exp_q[0].dut != d) begin
            check($sformatf("unexpected_rsp[%0d]", d), 32'h1, 32'h0);
          end else begin
            if (!in_rsp[d]) begin
              check($sformatf("rsp_latency[%0d]", d),
                    32'(cyc + 1 - exp_q[0].acc), 32'(exp_q[0].lat));
              in_rsp[d] = 1'b1;
            end
            check($sformatf("rsp_rdata[%0d]", d), rsp_rdata_a[d], exp_q[0].rdata);
            check($sformatf("rsp_error[%0d]", d), {31'h0, rsp_error_a[d]},
                  {31'h0, exp_q[0].err});
            check($sformatf("req_ready_in_resp[%0d]", d), {31'h0, req_ready_a[d]}, 32'h0);
            if (rsp_ready_a[d]) begin
              void'(exp_q.pop_front());
              in_rsp[d]  = 1'b0;
              retired[d] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic issue(input int d, input bit wr, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit exp_err);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_write_a[d]    = wr;
    req_addr_a[d]     = addr;
    req_size_a[d]     = size;
    req_unsigned_a[d] = uns;
    req_wdata_a[d]    = wdata;
    req_valid_a[d]    = 1'b1;
    while (!req_ready_a[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_a[d]) check("accept_timeout", 32'h0, 32'h1);
    e.dut   = d;
    e.rdata = (wr || exp_err) ? 32'h0 : exp_rdata;
    e.err   = exp_err;
    e.acc   = cyc + 1;
    e.lat   = exp_err ? 1 : 1 + ws_of(d);
    exp_q.push_back(e);
    last_acc[d] = cyc + 1;
    @(posedge clk);
    #1 req_valid_a[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc4 [4];
    int n;
    for (int d = 0; d < NDUT; d++) begin
      rst_a[d] = 1'b1;          req_valid_a[d] = 1'b0;
      req_write_a[d] = 1'b0;    req_addr_a[d] = '0;
      req_size_a[d] = 2'b10;    req_unsigned_a[d] = 1'b0;
      req_wdata_a[d] = '0;      rsp_ready_a[d] = 1'b1;
      in_rsp[d] = 1'b0;         retired[d] = 1'b0;
      last_acc[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_req_ready[%0d]", d), {31'h0, req_ready_a[d]}, 32'h1);
      check($sformatf("reset_rsp_valid[%0d]", d), {31'h0, rsp_valid_a[d]}, 32'h0);
      check($sformatf("reset_rsp_rdata[%0d]", d), rsp_rdata_a[d], 32'h0);
      check($sformatf("reset_rsp_error[%0d]", d), {31'h0, rsp_error_a[d]}, 32'h0);
      rst_a[d] = 1'b0;
    end

    // ---- DUT 0, WAIT_STATES = 1 ----
    issue(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 32'h20, 2'b10, 0, 32'h11223344, 32'h0, 0);
    issue(0, 1, 32'h21, 2'b00, 0, 32'hABCDEF80, 32'h0, 0);
    issue(0, 0, 32'h21, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0);
    issue(0, 0, 32'h21, 2'b00, 1, 32'h0, 32'h00000080, 0);
    issue(0, 0, 32'h20, 2'b10, 0, 32'h0, 32'h11228044, 0);
    issue(0, 1, 32'h22, 2'b01, 0, 32'h12345A5A, 32'h0, 0);
    issue(0, 0, 32'h22, 2'b01, 1, 32'h0, 32'h00005A5A, 0);
    issue(0, 0, 32'h22, 2'b01, 0, 32'h0, 32'h00005A5A, 0);
    issue(0, 0, 32'h20, 2'b10, 0, 32'h0, 32'h5A5A8044, 0);
    issue(0, 1, 32'h0C, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0);
    issue(0, 1, 32'h0E, 2'b10, 0, 32'h55555555, 32'h0, 1);
    issue(0, 0, 32'h0C, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0);
    issue(0, 0, 32'h03, 2'b01, 0, 32'h0, 32'h0, 1);
    issue(0, 0, 32'h1000, 2'b10, 0, 32'h0, 32'h0, 1);
    issue(0, 1, 32'h1000, 2'b10, 0, 32'h77777777, 32'h0, 1);
    issue(0, 0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1);
    issue(0, 1, 32'hFFC, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 0);
    issue(0, 0, 32'hFFC, 2'b10, 0, 32'h0, 32'hA5A5A5A5, 0);
    issue(0, 0, 32'hFFF, 2'b00, 0, 32'h0, 32'hFFFFFFA5, 0);
    drain();

    // Backpressure: hold the response for 5 cycles.
    rsp_ready_a[0] = 1'b0;
    issue(0, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
    n = 0;
    while (!rsp_valid_a[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_a[0]) check("bp_rsp_timeout", 32'h0, 32'h1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready_a[0] = 1'b1;
    drain();

    // ---- DUT 1, WAIT_STATES = 3: reset mid-WAIT drops the store ----
    issue(1, 1, 32'h40, 2'b10, 0, 32'h0, 32'h0, 0);
    issue(1, 0, 32'h42, 2'b10, 0, 32'h0, 32'h0, 1);
    drain();
    issue(1, 1, 32'h40, 2'b10, 0, 32'h12345678, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_a[1] = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midwait_rst_req_ready", {31'h0, req_ready_a[1]}, 32'h1);
    check("midwait_rst_rsp_valid", {31'h0, rsp_valid_a[1]}, 32'h0);
    check("midwait_rst_rsp_rdata", rsp_rdata_a[1], 32'h0);
    check("midwait_rst_rsp_error", {31'h0, rsp_error_a[1]}, 32'h0);
    rst_a[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("midwait_no_rsp", {31'h0, rsp_valid_a[1]}, 32'h0);
    issue(1, 0, 32'h40, 2'b10, 0, 32'h0, 32'h0, 0);
    drain();

    // ---- DUT 2, WAIT_STATES = 0: back-to-back loads ----
    issue(2, 1, 32'h0, 2'b10, 0, 32'h01234567, 32'h0, 0);
    issue(2, 1, 32'h4, 2'b10, 0, 32'h89ABCDEF, 32'h0, 0);
    issue(2, 1, 32'h8, 2'b10, 0, 32'h00FF7F80, 32'h0, 0);
    drain();
    issue(2, 0, 32'h0, 2'b10, 0, 32'h0, 32'h01234567, 0);
    acc4[0] = last_acc[2];
    issue(2, 0, 32'h6, 2'b01, 1, 32'h0, 32'h000089AB, 0);
    acc4[1] = last_acc[2];
    issue(2, 0, 32'h6, 2'b01, 0, 32'h0, 32'hFFFF89AB, 0);
    acc4[2] = last_acc[2];
    issue(2, 0, 32'h8, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0);
    acc4[3] = last_acc[2];
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_accept_spacing[%0d]", i), 32'(acc4[i] - acc4[i-1]), 32'h2);
    drain();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the target side of the core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs byte, half and word accesses with sign or zero extension, and flags misaligned or out-of-range accesses. It sits between the core's memory stage and on-chip RAM, and replaces the zero-latency data memory once the core moves to a handshaked memory port.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 1: cycles spent in WAIT before the access commits; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- req_wdata  in  32  store data; the low bytes are used for sub-word stores.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and for errors.
- rsp_error  out  1  access was misaligned, out of range or illegal-size.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready = 1, rsp_valid = 0.
  - On req_valid && req_ready the responder latches write, addr, size, unsigned and wdata.
  - Next state: WAIT if WAIT_STATES > 0 and the request is legal; otherwise RESP.
- Error check, evaluated at acceptance. A request is in error when any of these holds:
  - req_size = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr >= 4*DEPTH_WORDS.
- Error handling: an erroring request goes straight to RESP with rsp_error = 1 and rsp_rdata = 0. Memory is never written.
- WAIT
  - A 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - When the counter is 0, the access commits and the FSM moves to RESP.
  - req_ready = 0 throughout.
- Commit
  - Store: byte enables come from size and addr[1:0]. Byte stores write wdata[7:0] to lane addr[1:0]. Half stores write wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1. Word stores write all four lanes.
  - Load: the selected lane(s) are shifted to bit 0, then extended per req_unsigned. Word loads ignore req_unsigned.
  - Commit happens exactly once per accepted request.
- RESP
  - rsp_valid = 1; rsp_rdata and rsp_error are registered and held stable until rsp_ready = 1.
  - On rsp_ready the FSM returns to IDLE.
  - There is no pass-through: a new request cannot be accepted in the same cycle a response retires.
- Reset
  - Outputs: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - State returns to IDLE and the counter is cleared.
  - Memory contents are not cleared.
  - Reset during WAIT drops the pending access; an uncommitted store never writes.
  - Reset during RESP discards the response.

## Timing
- Acceptance at rising edge N: commit at edge N+WAIT_STATES, rsp_valid high from cycle N+1+WAIT_STATES.
- WAIT_STATES = 0: the commit occurs at the acceptance edge and rsp_valid is high in cycle N+1.
- Error responses: rsp_valid is high in cycle N+1 regardless of WAIT_STATES.
- Peak throughput: one transaction per WAIT_STATES+2 cycles when rsp_ready is held high.
- Read-after-write: a store's data is visible to any load accepted after the store's response.
- req_* inputs are sampled only at the accept edge and may change freely afterward.
- rsp_ready asserted while rsp_valid = 0 is ignored.

## Structure
- Package dmem_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W;
  - the FSM state enum (IDLE/WAIT/RESP);
  - the 4-bit wait-counter width constant.
- Sub-module dmem_lane: combinational. Inputs: size, addr[1:0], unsigned, wdata, raw read word. Outputs: 4-bit byte enable, lane-aligned write word, extended load data.
- The storage array, FSM and counter live in dmem_responder. The array is inferred as a synchronous-write, registered-read-at-commit RAM.

## Test plan
- Word store then load, WAIT_STATES = 1: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata = 0xDEADBEEF, rsp_error = 0. Each rsp_valid appears 2 cycles after acceptance.
- Sub-word extension: SB 0x80 @0x21, then LB @0x21 → 0xFFFFFF80, LBU @0x21 → 0x00000080. A following LW @0x20 shows only byte lane 1 changed.
- Misalignment and range, all with rsp_error = 1, rsp_rdata = 0 and rsp_valid 1 cycle after acceptance:
  - LH @0x03;
  - SW @0x0E, after which a subsequent LW @0x0C shows unchanged data;
  - LW @4*DEPTH_WORDS;
  - size = 11.
- Backpressure: hold rsp_ready = 0 for 5 cycles during RESP → rsp_valid and rsp_rdata stay stable and req_ready stays 0. Release → IDLE next cycle, req_ready = 1.
- Reset mid-WAIT, WAIT_STATES = 3: accept SW 0x12345678 @0x40 over 0x0, assert rst in the second WAIT cycle. Outputs return to their reset values, and a later LW @0x40 returns 0x0.
- WAIT_STATES = 0 back-to-back with rsp_ready held high: 4 loads complete in 8 cycles, with no dropped or duplicated responses.
